// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the regfile_sb register file and its
// pending-write scoreboard.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam bit DEF_ZERO_REG = 1'b1;

  // An index may hold state unless it is register 0 and register 0 is
  // hardwired; callers use this to mask writes, issues and reads of x0.
  function automatic logic idx_valid(input int unsigned idx, input bit zero_reg);
    return !(zero_reg && (idx == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register marking an in-flight
// producer, plus a running count of set bits. An issue in the same cycle as
// a writeback to the same index keeps the bit set (the newer producer wins).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  output logic [DEPTH-1:0] pending,
  output logic [AW:0]      count
);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [AW:0]      count_q, count_d;
  logic             set_v, clr_v;
  logic             inc, dec;

  // Next pending vector and count: clear from writeback, then set from
  // issue so that a same-index collision leaves the bit set.
  always_comb begin
    set_v     = set_en && idx_valid(32'(set_idx), ZERO_REG);
    clr_v     = clr_en && idx_valid(32'(clr_idx), ZERO_REG);
    pending_d = pending_q;
    if (clr_v) pending_d[clr_idx] = 1'b0;
    if (set_v) pending_d[set_idx] = 1'b1;
    // Count moves only on real 0->1 and 1->0 transitions of the vector, so
    // it tracks popcount without ever recounting the whole vector.
    inc     = set_v && !pending_q[set_idx];
    dec     = clr_v && pending_q[clr_idx] && !(set_v && (set_idx == clr_idx));
    count_d = count_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  // Scoreboard state; reset empties it and overrides any same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending = pending_q;
  assign count   = count_q;

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with two combinational read ports, one
// writeback port and a per-register pending-write scoreboard for the hazard
// unit. Register 0 can be hardwired to zero (ZERO_REG).
// Optional feature macro: REGFILE_BYPASS_EN -- forwards the writeback data
// (and a cleared busy flag) to a read port in the same cycle as the write.
// Without it, reads see stored state only and a write shows up next cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite,
  input  logic [AW-1:0]    Write_register,
  input  logic [WIDTH-1:0] Write_data,
  input  logic             Issue_valid,
  input  logic [AW-1:0]    Issue_rd,
  input  logic [AW-1:0]    Rs1,
  input  logic [AW-1:0]    Rs2,
  output logic [WIDTH-1:0] Rd1,
  output logic [WIDTH-1:0] Rd2,
  output logic             Busy1,
  output logic             Busy2,
  output logic [AW:0]      Pending_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             we_v;
  logic [WIDTH-1:0] rd1_stored, rd2_stored;

  // Qualified write: reset suppresses it, and x0 is masked when hardwired.
  always_comb begin
    we_v = RegWrite && !rst && idx_valid(32'(Write_register), ZERO_REG);
  end

  // Next array contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we_v) mem_d[Write_register] = Write_data;
  end

  // Register array; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .clr_en  (RegWrite),
    .clr_idx (Write_register),
    .set_en  (Issue_valid),
    .set_idx (Issue_rd),
    .pending (pending),
    .count   (Pending_count)
  );

  // Stored read data; x0 is forced to zero when hardwired.
  always_comb begin
    rd1_stored = idx_valid(32'(Rs1), ZERO_REG) ? mem_q[Rs1] : '0;
    rd2_stored = idx_valid(32'(Rs2), ZERO_REG) ? mem_q[Rs2] : '0;
  end

  // Read port 1: stored state, optionally overridden by same-cycle forwarding.
  always_comb begin
    Rd1   = rd1_stored;
    Busy1 = pending[Rs1];
`ifdef REGFILE_BYPASS_EN
    if (we_v && (Write_register == Rs1)) begin
      Rd1 = Write_data;
      // A new producer issued to the same register this cycle keeps the
      // stored busy view; otherwise the arriving value retires the hazard.
      if (!(Issue_valid && (Issue_rd == Rs1))) Busy1 = 1'b0;
    end
`endif
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    Rd2   = rd2_stored;
    Busy2 = pending[Rs2];
`ifdef REGFILE_BYPASS_EN
    if (we_v && (Write_register == Rs2)) begin
      Rd2 = Write_data;
      if (!(Issue_valid && (Issue_rd == Rs2))) Busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 32x32 instance driven by directed and random
// steps against an array-based reference model, and a 16x8 instance
// exercising full scoreboard occupancy.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic        rst = 1'b1, we = 1'b0, iv = 1'b0;
  logic [4:0]  wr = '0, ird = '0, rs1 = '0, rs2 = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd1, rd2;
  logic        b1, b2;
  logic [5:0]  cnt;

  regfile_sb dut (
    .clk(clk), .rst(rst), .RegWrite(we), .Write_register(wr), .Write_data(wd),
    .Issue_valid(iv), .Issue_rd(ird), .Rs1(rs1), .Rs2(rs2),
    .Rd1(rd1), .Rd2(rd2), .Busy1(b1), .Busy2(b2), .Pending_count(cnt)
  );

  // Small instance
  logic        s_rst = 1'b1, s_we = 1'b0, s_iv = 1'b0;
  logic [2:0]  s_wr = '0, s_ird = '0, s_rs1 = '0, s_rs2 = '0;
  logic [15:0] s_wd = '0;
  logic [15:0] s_rd1, s_rd2;
  logic        s_b1, s_b2;
  logic [3:0]  s_cnt;

  regfile_sb #(.WIDTH(16), .DEPTH(8)) dut_s (
    .clk(clk), .rst(s_rst), .RegWrite(s_we), .Write_register(s_wr), .Write_data(s_wd),
    .Issue_valid(s_iv), .Issue_rd(s_ird), .Rs1(s_rs1), .Rs2(s_rs2),
    .Rd1(s_rd1), .Rd2(s_rd2), .Busy1(s_b1), .Busy2(s_b2), .Pending_count(s_cnt)
  );

  // Reference model of the default instance: register contents and the set
  // of registers with an outstanding producer.
  logic [31:0] m_reg [32];
  bit          m_pend [32];

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic fwd_hit(input logic [4:0] rs);
`ifdef REGFILE_BYPASS_EN
    return we && !rst && (wr == rs) && (rs != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] rs);
    if (fwd_hit(rs)) return wd;
    return (rs == 0) ? 32'h0 : m_reg[rs];
  endfunction

  function automatic logic exp_busy(input logic [4:0] rs);
    if (rs == 0) return 1'b0;
    if (fwd_hit(rs) && !(iv && (ird == rs))) return 1'b0;
    return m_pend[rs];
  endfunction

  // One clock of the default instance: optionally compare all outputs to the
  // model on the falling edge, then apply the inputs to the model at the
  // rising edge.
  task automatic tick(input bit do_chk);
    @(negedge clk);
    if (do_chk) begin
      chk("rd1",   rd1, exp_rd(rs1));
      chk("rd2",   rd2, exp_rd(rs2));
      chk("busy1", 32'(b1), 32'(exp_busy(rs1)));
      chk("busy2", 32'(b2), 32'(exp_busy(rs2)));
      chk("count", 32'(cnt), 32'(m_cnt()));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && wr != 0) begin
        m_reg[wr]  = wd;
        m_pend[wr] = 1'b0;
      end
      if (iv && ird != 0) m_pend[ird] = 1'b1;
    end
    #1;
  endtask

  task automatic stick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 'x;
      m_pend[i] = 1'b0;
    end

    // Initial reset
    rst = 1'b1; tick(1'b0);
    rst = 1'b0; tick(1'b1);

    // Reset clears data and ignores a same-cycle write
    we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; rs1 = 5'd5; rs2 = 5'd6; tick(1'b1);
    rst = 1'b1; wr = 5'd6; wd = 32'h11111111; tick(1'b1);
    rst = 1'b0; we = 1'b0; #1;
    chk("reset_x5", rd1, 32'h0);
    chk("reset_x6", rd2, 32'h0);
    chk("reset_cnt", 32'(cnt), 32'h0);
    tick(1'b1);

    // Hardwired x0
    we = 1'b1; wr = 5'd0; wd = 32'h12345678; iv = 1'b1; ird = 5'd0; rs1 = 5'd0; tick(1'b1);
    we = 1'b0; iv = 1'b0; #1;
    chk("zero_rd",   rd1, 32'h0);
    chk("zero_busy", 32'(b1), 32'h0);
    chk("zero_cnt",  32'(cnt), 32'h0);

    // Scoreboard set and clear
    iv = 1'b1; ird = 5'd3; tick(1'b1);
    ird = 5'd7; tick(1'b1);
    iv = 1'b0; rs1 = 5'd3; rs2 = 5'd7; #1;
    chk("sb_cnt2",   32'(cnt), 32'd2);
    chk("sb_busy3",  32'(b1), 32'd1);
    we = 1'b1; wr = 5'd3; wd = 32'hA5A5A5A5; tick(1'b1);
    we = 1'b0; #1;
    chk("sb_cnt1",   32'(cnt), 32'd1);
    chk("sb_busy3c", 32'(b1), 32'd0);
    chk("sb_rd3",    rd1, 32'hA5A5A5A5);
    chk("sb_busy7",  32'(b2), 32'd1);

    // Write and issue to the same pending register
    iv = 1'b1; ird = 5'd9; tick(1'b1);
    we = 1'b1; wr = 5'd9; wd = 32'h0BADF00D; tick(1'b1);
    we = 1'b0; iv = 1'b0; rs1 = 5'd9; #1;
    chk("waw_rd9",   rd1, 32'h0BADF00D);
    chk("waw_busy9", 32'(b1), 32'd1);
    chk("waw_cnt",   32'(cnt), 32'd2);

    // Same-cycle read of a register being written
    we = 1'b1; wr = 5'd4; wd = 32'h11110000; rs1 = 5'd0; tick(1'b1);
    wd = 32'h0000CAFE; rs1 = 5'd4; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd1, 32'h0000CAFE);
`else
    chk("byp_same", rd1, 32'h11110000);
`endif
    tick(1'b1);
    we = 1'b0; #1;
    chk("byp_next", rd1, 32'h0000CAFE);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      iv  = 1'($urandom_range(0, 1));
      wr  = 5'($urandom_range(0, 31));
      ird = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      wd  = $urandom;
      rs1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 2) == 0) ? ird : 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 99) == 0);
      tick(1'b1);
    end
    rst = 1'b0; we = 1'b0; iv = 1'b0;
    tick(1'b1);

    // Small instance: fill and drain the scoreboard
    s_rst = 1'b1; stick();
    s_rst = 1'b0; #1;
    chk("s_reset_cnt", 32'(s_cnt), 32'd0);
    s_iv = 1'b1; s_ird = 3'd0; stick();
    chk("s_zero_cnt", 32'(s_cnt), 32'd0);
    for (int i = 1; i < 8; i++) begin
      s_ird = 3'(i); stick();
      chk("s_issue_cnt", 32'(s_cnt), 32'(i));
    end
    s_iv = 1'b0;
    s_ird = 3'd1; stick();
    chk("s_full_cnt", 32'(s_cnt), 32'd7);
    s_rs1 = 3'd7; s_rs2 = 3'd0; #1;
    chk("s_busy7", 32'(s_b1), 32'd1);
    chk("s_busy0", 32'(s_b2), 32'd0);
    s_we = 1'b1;
    for (int i = 1; i < 8; i++) begin
      s_wr = 3'(i); s_wd = 16'hA000 + 16'(i); stick();
      chk("s_write_cnt", 32'(s_cnt), 32'(7 - i));
    end
    s_we = 1'b0;
    for (int i = 1; i < 8; i++) begin
      s_rs1 = 3'(i); s_rs2 = 3'(8 - i); #1;
      chk("s_rd1",   32'(s_rd1), 32'(16'hA000 + 16'(i)));
      chk("s_rd2",   32'(s_rd2), 32'(16'hA000 + 16'(8 - i)));
      chk("s_busy1", 32'(s_b1), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
